adder_pipe: RTL and testbench

//   Parametrised successor of the 8-bit valid-only adder: N-bit add/subtract with

---
 rtl/adder_pkg.sv | 31 +++
 rtl/adder_pipe_slice.sv | 30 +++
 rtl/adder_pipe.sv | 95 +++++++++
 tb/tb_adder_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the handshaked add/subtract pipeline.
// Saturation bounds are produced at the widest supported width and narrowed by the caller.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned MAX_W = 64;

  // Clamp value for an overflowed result. raw_msb is the sign bit of the wrapped
  // result: in signed mode a wrapped-negative result means positive overflow.
  function automatic logic [MAX_W-1:0] sat_result(
    input logic        raw_msb,
    input op_e         op,
    input logic        signed_mode,
    input int unsigned width
  );
    logic [MAX_W-1:0] msb_only;
    logic [MAX_W-1:0] sat;
    msb_only = 64'd1 << (width - 1);
    if (signed_mode) begin
      sat = raw_msb ? (msb_only - 64'd1) : msb_only;
    end else begin
      sat = (op == OP_SUB) ? '0 : ({MAX_W{1'b1}} >> (MAX_W - width));
    end
    return sat;
  endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// One valid/ready register stage. Loads when empty or when its current contents
// leave in the same cycle, so a full chain still streams one beat per clock.
module adder_pipe_slice #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  output logic in_rdy,
  input  T     in_data,
  output logic out_vld,
  input  logic out_rdy,
  output T     out_data
);

  assign in_rdy = ~out_vld | out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// N-bit add/subtract with valid/ready on both sides. All arithmetic happens in
// front of the first register; the remaining stages only delay the result.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PIPE_STG = 2,
  parameter int SIGNED   = 0,
  parameter int SAT_EN   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in_vld,
  output logic              data_in_rdy,
  input  logic              op_sub,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  output logic              data_out_vld,
  input  logic              data_out_rdy,
  output logic [DATA_W-1:0] data_out,
  output logic              carry_out,
  output logic              ovf
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              ovf;
  } result_t;

  op_e             op;
  logic [DATA_W:0] raw;
  logic            ovf_signed;
  result_t         res;

  assign op = op_e'(op_sub);

  always_comb begin
    if (op == OP_SUB) begin
      raw = {1'b0, data_in0} - {1'b0, data_in1};
    end else begin
      raw = {1'b0, data_in0} + {1'b0, data_in1};
    end
    // Subtraction negates B, so its effective sign is inverted.
    ovf_signed = (data_in0[DATA_W-1] == (data_in1[DATA_W-1] ^ (op == OP_SUB))) &&
                 (raw[DATA_W-1] != data_in0[DATA_W-1]);
    res.carry = raw[DATA_W];
    res.ovf   = (SIGNED != 0) ? ovf_signed : raw[DATA_W];
    res.data  = raw[DATA_W-1:0];
    if ((SAT_EN != 0) && res.ovf) begin
      res.data = DATA_W'(sat_result(raw[DATA_W-1], op, SIGNED != 0, DATA_W));
    end
  end

  logic    stg_vld  [PIPE_STG+1];
  result_t stg_data [PIPE_STG+1];

  assign stg_vld[0]  = data_in_vld;
  assign stg_data[0] = res;

  // Each stage keeps its own ready net so the combinational ready chain from the
  // sink back to data_in_rdy is a plain acyclic path.
  generate
    for (genvar gi = 0; gi < PIPE_STG; gi++) begin : g_stg
      logic rdy_in;
      logic rdy_out;

      if (gi == PIPE_STG - 1) begin : g_last
        assign rdy_out = data_out_rdy;
      end else begin : g_mid
        assign rdy_out = g_stg[gi+1].rdy_in;
      end

      adder_pipe_slice #(
        .T(result_t)
      ) u_slice (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (stg_vld[gi]),
        .in_rdy   (rdy_in),
        .in_data  (stg_data[gi]),
        .out_vld  (stg_vld[gi+1]),
        .out_rdy  (rdy_out),
        .out_data (stg_data[gi+1])
      );
    end
  endgenerate

  assign data_in_rdy  = g_stg[0].rdy_in;
  assign data_out_vld = stg_vld[PIPE_STG];
  assign data_out     = stg_data[PIPE_STG].data;
  assign carry_out    = stg_data[PIPE_STG].carry;
  assign ovf          = stg_data[PIPE_STG].ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: five 8-bit instances (wrap/saturate, unsigned/signed,
// depths 1, 2 and 4) checked against an integer-arithmetic scoreboard.
module tb_adder_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       ovf;
  } exp_t;

  localparam int NDUT = 5;
  localparam int PIPE [NDUT] = '{2, 2, 2, 1, 4};
  localparam int SGN  [NDUT] = '{0, 0, 1, 0, 1};
  localparam int SAT  [NDUT] = '{0, 1, 1, 0, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld_main = 1'b0;
  logic       vld_alt = 1'b0;
  logic       op_in = 1'b0;
  logic       out_rdy = 1'b1;
  logic [7:0] a_in = 8'd0;
  logic [7:0] b_in = 8'd0;

  logic       i_rdy   [NDUT];
  logic       o_vld   [NDUT];
  logic       o_carry [NDUT];
  logic       o_ovf   [NDUT];
  logic [7:0] o_data  [NDUT];

  int   checks = 0;
  int   errors = 0;
  int   pops0 = 0;
  logic acc = 1'b0;
  exp_t q [NDUT][$];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      adder_pipe #(
        .DATA_W   (8),
        .PIPE_STG (PIPE[gi]),
        .SIGNED   (SGN[gi]),
        .SAT_EN   (SAT[gi])
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_in_vld  ((gi < 3) ? vld_main : vld_alt),
        .data_in_rdy  (i_rdy[gi]),
        .op_sub       (op_in),
        .data_in0     (a_in),
        .data_in1     (b_in),
        .data_out_vld (o_vld[gi]),
        .data_out_rdy (out_rdy),
        .data_out     (o_data[gi]),
        .carry_out    (o_carry[gi]),
        .ovf          (o_ovf[gi])
      );
    end
  endgenerate

  // Reference: exact integer result, then range tests decide flags and clamping.
  function automatic exp_t model(int d, logic [7:0] a, logic [7:0] b, logic sub);
    exp_t r;
    int   ua, ub, us, sa, sb, ss, v;
    ua = int'(a);
    ub = int'(b);
    us = sub ? ua - ub : ua + ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ss = sub ? sa - sb : sa + sb;
    r.carry = (us < 0) || (us > 255);
    if (SGN[d] != 0) begin
      r.ovf = (ss > 127) || (ss < -128);
      v = ss;
      if (SAT[d] != 0 && ss > 127)  v = 127;
      if (SAT[d] != 0 && ss < -128) v = -128;
    end else begin
      r.ovf = r.carry;
      v = us;
      if (SAT[d] != 0 && us > 255) v = 255;
      if (SAT[d] != 0 && us < 0)   v = 0;
    end
    r.data = v[7:0];
    return r;
  endfunction

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
    end
  endtask

  // One clock: observe handshakes on the falling edge, then advance past the rising edge.
  task automatic step();
    logic v;
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      v = (d < 3) ? vld_main : vld_alt;
      if (!rst && v && i_rdy[d]) begin
        q[d].push_back(model(d, a_in, b_in, op_in));
        if (d == 0) acc = 1'b1;
      end
      if (!rst && o_vld[d] && out_rdy) begin
        checks++;
        assert (q[d].size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected dut%0d: observed output %0d expected none", d, o_data[d]);
        end
        if (q[d].size() > 0) begin
          e = q[d].pop_front();
          chk("sb_data", d, 32'(o_data[d]), 32'(e.data));
          chk("sb_carry", d, 32'(o_carry[d]), 32'(e.carry));
          chk("sb_ovf", d, 32'(o_ovf[d]), 32'(e.ovf));
          if (d == 0) pops0++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Push one beat into the depth-2 instances and park it at their outputs.
  task automatic one_beat(logic [7:0] a, logic [7:0] b, logic sub);
    a_in = a;
    b_in = b;
    op_in = sub;
    vld_main = 1'b1;
    out_rdy = 1'b0;
    step();
    vld_main = 1'b0;
    for (int d = 0; d < 3; d++) chk("lat_early", d, 32'(o_vld[d]), 32'd0);
    step();
    for (int d = 0; d < 3; d++) chk("lat_out", d, 32'(o_vld[d]), 32'd1);
    step();
    for (int d = 0; d < 3; d++) chk("hold_vld", d, 32'(o_vld[d]), 32'd1);
  endtask

  task automatic release_beat();
    out_rdy = 1'b1;
    step();
    for (int d = 0; d < 3; d++) chk("drained", d, 32'(o_vld[d]), 32'd0);
  endtask

  task automatic new_beat();
    a_in = 8'($urandom_range(0, 255));
    b_in = 8'($urandom_range(0, 255));
    op_in = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int n_acc;
    int sent;
    int lat [NDUT];

    // Reset held with valid asserted: nothing may emerge.
    vld_main = 1'b1;
    vld_alt = 1'b1;
    a_in = 8'd3;
    b_in = 8'd4;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int d = 0; d < NDUT; d++) chk("rst_vld", d, 32'(o_vld[d]), 32'd0);
    end
    for (int d = 0; d < NDUT; d++) chk("rst_data", d, 32'(o_data[d]), 32'd0);
    vld_main = 1'b0;
    vld_alt = 1'b0;
    rst = 1'b0;
    step();
    for (int d = 0; d < NDUT; d++) chk("rdy_after_rst", d, 32'(i_rdy[d]), 32'd1);

    one_beat(8'd3, 8'd4, 1'b0);
    chk("u_3p4_data", 0, 32'(o_data[0]), 32'd7);
    chk("u_3p4_carry", 0, 32'(o_carry[0]), 32'd0);
    chk("u_3p4_ovf", 0, 32'(o_ovf[0]), 32'd0);
    release_beat();

    one_beat(8'd200, 8'd100, 1'b0);
    chk("u_wrap_add_data", 0, 32'(o_data[0]), 32'd44);
    chk("u_wrap_add_carry", 0, 32'(o_carry[0]), 32'd1);
    chk("u_wrap_add_ovf", 0, 32'(o_ovf[0]), 32'd1);
    chk("u_sat_add_data", 1, 32'(o_data[1]), 32'd255);
    chk("u_sat_add_ovf", 1, 32'(o_ovf[1]), 32'd1);
    release_beat();

    one_beat(8'd5, 8'd10, 1'b1);
    chk("u_wrap_sub_data", 0, 32'(o_data[0]), 32'd251);
    chk("u_wrap_sub_carry", 0, 32'(o_carry[0]), 32'd1);
    chk("u_wrap_sub_ovf", 0, 32'(o_ovf[0]), 32'd1);
    chk("u_sat_sub_data", 1, 32'(o_data[1]), 32'd0);
    chk("u_sat_sub_ovf", 1, 32'(o_ovf[1]), 32'd1);
    release_beat();

    one_beat(8'd100, 8'd100, 1'b0);
    chk("s_sat_pos_data", 2, 32'(o_data[2]), 32'd127);
    chk("s_sat_pos_ovf", 2, 32'(o_ovf[2]), 32'd1);
    release_beat();

    one_beat(8'd156, 8'd156, 1'b0);
    chk("s_sat_neg_data", 2, 32'(o_data[2]), 32'd128);
    chk("s_sat_neg_ovf", 2, 32'(o_ovf[2]), 32'd1);
    release_beat();

    one_beat(8'd251, 8'd3, 1'b0);
    chk("s_small_data", 2, 32'(o_data[2]), 32'd254);
    chk("s_small_ovf", 2, 32'(o_ovf[2]), 32'd0);
    release_beat();

    // Stream of 20 beats: sink stalled for 6 cycles first, then random ready.
    pops0 = 0;
    n_acc = 0;
    sent = 0;
    out_rdy = 1'b0;
    new_beat();
    vld_main = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (acc) begin
        n_acc++;
        sent++;
        new_beat();
      end
    end
    chk("stall_accepts", 0, 32'(n_acc), 32'd2);
    for (int d = 0; d < 3; d++) chk("stall_rdy", d, 32'(i_rdy[d]), 32'd0);
    for (int c = 0; c < 400 && sent < 20; c++) begin
      out_rdy = 1'($urandom_range(0, 1));
      step();
      if (acc) begin
        sent++;
        if (sent < 20) new_beat();
        else vld_main = 1'b0;
      end
    end
    vld_main = 1'b0;
    chk("stream_sent", 0, 32'(sent), 32'd20);
    out_rdy = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("stream_results", 0, 32'(pops0), 32'd20);
    for (int d = 0; d < 3; d++) chk("stream_left", d, 32'(q[d].size()), 32'd0);

    // Reset with beats in flight at every depth, then latency after release.
    out_rdy = 1'b1;
    vld_main = 1'b1;
    vld_alt = 1'b1;
    new_beat();
    step();
    new_beat();
    step();
    vld_main = 1'b0;
    vld_alt = 1'b0;
    rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_async_vld", d, 32'(o_vld[d]), 32'd0);
      q[d].delete();
    end
    for (int c = 0; c < 2; c++) begin
      step();
      for (int d = 0; d < NDUT; d++) chk("rst_mid_vld", d, 32'(o_vld[d]), 32'd0);
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < NDUT; d++) chk("no_stale_out", d, 32'(o_vld[d]), 32'd0);
    new_beat();
    vld_main = 1'b1;
    vld_alt = 1'b1;
    step();
    vld_main = 1'b0;
    vld_alt = 1'b0;
    for (int d = 0; d < NDUT; d++) lat[d] = 0;
    for (int s = 1; s <= 8; s++) begin
      for (int d = 0; d < NDUT; d++) begin
        if (o_vld[d] && lat[d] == 0) lat[d] = s;
      end
      step();
    end
    for (int d = 0; d < NDUT; d++) begin
      chk("post_rst_latency", d, 32'(lat[d]), 32'(PIPE[d]));
      chk("post_rst_left", d, 32'(q[d].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
